// File: rtl/contador_regressivo_if.sv
// rtl/contador_regressivo_if.sv - control/status bundle for the countdown timer
//
// Purpose: groups the command inputs and the registered status outputs of
// contador_regressivo so they can be passed as a single port.
// Signals:
//   iniciar, cancelar, pausa, en, auto : commands (master -> slave)
//   D [N-1:0]                          : start/reload value (master -> slave)
//   Q [N-1:0]                          : current count (slave -> master)
//   rco, fim, ativo                    : status flags (slave -> master)
interface contador_regressivo_if #(
  parameter int N = 16
);
  logic         iniciar;
  logic         cancelar;
  logic         pausa;
  logic         en;
  logic         auto;
  logic [N-1:0] D;
  logic [N-1:0] Q;
  logic         rco;
  logic         fim;
  logic         ativo;

  modport master (
    output iniciar, cancelar, pausa, en, auto, D,
    input  Q, rco, fim, ativo
  );

  modport slave (
    input  iniciar, cancelar, pausa, en, auto, D,
    output Q, rco, fim, ativo
  );
endinterface

// File: rtl/contador_regressivo.sv
// rtl/contador_regressivo.sv - programmable down-counter with pause, cancel and auto-reload
//
// Purpose: loads D on iniciar, decrements once per en tick, and pulses rco for
// one cycle on the terminal tick (the tick taken while Q is already 0). With
// auto set the count reloads from D, otherwise the block parks in FIM.
// Ports:
//   clock : rising-edge clock
//   clr_n : asynchronous active-low reset
//   bus   : contador_regressivo_if.slave (commands in, Q/rco/fim/ativo out)
// All outputs are flop outputs.
module contador_regressivo #(
  parameter int N = 16
) (
  input  logic                  clock,
  input  logic                  clr_n,
  contador_regressivo_if.slave  bus
);

  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } state_t;

  state_t       state;
  logic [N-1:0] q;
  logic         rco;
  logic         fim;
  logic         ativo;

  assign bus.Q     = q;
  assign bus.rco   = rco;
  assign bus.fim   = fim;
  assign bus.ativo = ativo;

  always_ff @(posedge clock or negedge clr_n) begin
    if (!clr_n) begin
      state <= PARADO;
      q     <= '0;
      rco   <= 1'b0;
      fim   <= 1'b0;
      ativo <= 1'b0;
    end else begin
      // rco is a single-cycle pulse: only the terminal-tick branch sets it.
      rco <= 1'b0;
      if (bus.cancelar) begin
        state <= PARADO;
        q     <= '0;
        fim   <= 1'b0;
        ativo <= 1'b0;
      end else if (bus.iniciar) begin
        state <= CONTANDO;
        q     <= bus.D;
        fim   <= 1'b0;
        ativo <= 1'b1;
      end else begin
        case (state)
          PARADO: begin
            // en and pausa have no effect while idle
          end
          CONTANDO: begin
            if (bus.pausa) begin
              // Entering pause consumes this edge; en is ignored here.
              state <= PAUSADO;
            end else if (bus.en) begin
              if (q != '0) begin
                q <= q - N'(1);
              end else begin
                // Terminal tick: Q=0 is handled here so the decrement never wraps.
                rco <= 1'b1;
                if (bus.auto) begin
                  q <= bus.D;
                end else begin
                  state <= FIM;
                  fim   <= 1'b1;
                  ativo <= 1'b0;
                end
              end
            end
          end
          PAUSADO: begin
            // Resume edge carries no decrement; the next tick counts.
            if (!bus.pausa) begin
              state <= CONTANDO;
            end
          end
          FIM: begin
            // Parked at zero until iniciar, cancelar or reset.
          end
          default: begin
            state <= PARADO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_contador_regressivo.sv
// tb/tb_contador_regressivo.sv - vector-table bench for contador_regressivo
module tb_contador_regressivo;

  localparam int N = 16;

  logic clock;
  logic clr_n;

  contador_regressivo_if #(.N(N)) bus ();

  contador_regressivo #(.N(N)) dut (
    .clock (clock),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         iniciar;
    logic         cancelar;
    logic         pausa;
    logic         en;
    logic         auto;
    logic [N-1:0] d;
    logic [N-1:0] q;
    logic         rco;
    logic         fim;
    logic         ativo;
  } vec_t;

  vec_t vecs[$];
  int   applied;
  int   miscompares;

  function automatic void add(input logic ini, input logic can, input logic pau,
                              input logic en_i, input logic aut, input int d,
                              input int q, input logic rco, input logic fim,
                              input logic ativo);
    vec_t v;
    v.iniciar  = ini;
    v.cancelar = can;
    v.pausa    = pau;
    v.en       = en_i;
    v.auto     = aut;
    v.d        = N'(d);
    v.q        = N'(q);
    v.rco      = rco;
    v.fim      = fim;
    v.ativo    = ativo;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic ini, input logic can, input logic pau,
                       input logic en_i, input logic aut, input logic [N-1:0] d);
    bus.iniciar  = ini;
    bus.cancelar = can;
    bus.pausa    = pau;
    bus.en       = en_i;
    bus.auto     = aut;
    bus.D        = d;
  endtask

  task automatic check(input string name, input logic [N-1:0] q, input logic rco,
                       input logic fim, input logic ativo);
    applied++;
    if (bus.Q !== q || bus.rco !== rco || bus.fim !== fim || bus.ativo !== ativo) begin
      miscompares++;
      $display("FAIL %s: got Q=%0d rco=%b fim=%b ativo=%b, want Q=%0d rco=%b fim=%b ativo=%b",
               name, bus.Q, bus.rco, bus.fim, bus.ativo, q, rco, fim, ativo);
    end
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;

    // 1: D=3 countdown, single rco, parks in FIM
    add(1,0,0,1,0, 3,  3,0,0,1);
    add(0,0,0,1,0, 3,  2,0,0,1);
    add(0,0,0,1,0, 3,  1,0,0,1);
    add(0,0,0,1,0, 3,  0,0,0,1);
    add(0,0,0,1,0, 3,  0,1,1,0);
    add(0,0,0,1,0, 3,  0,0,1,0);
    add(0,0,0,1,0, 3,  0,0,1,0);
    // 2: auto reload D=2, 12 ticks, 4 pulses, fim never set
    add(1,0,0,1,1, 2,  2,0,0,1);
    for (int p = 0; p < 4; p++) begin
      add(0,0,0,1,1, 2,  1,0,0,1);
      add(0,0,0,1,1, 2,  0,0,0,1);
      add(0,0,0,1,1, 2,  2,1,0,1);
    end
    // 3: pause at Q=3 for 4 edges, resume edge holds, then finish
    add(1,0,0,1,0, 5,  5,0,0,1);
    add(0,0,0,1,0, 5,  4,0,0,1);
    add(0,0,0,1,0, 5,  3,0,0,1);
    for (int p = 0; p < 4; p++) add(0,0,1,1,0, 5,  3,0,0,1);
    add(0,0,0,1,0, 5,  3,0,0,1);
    add(0,0,0,1,0, 5,  2,0,0,1);
    add(0,0,0,1,0, 5,  1,0,0,1);
    add(0,0,0,1,0, 5,  0,0,0,1);
    add(0,0,0,1,0, 5,  0,1,1,0);
    // 4: cancelar beats iniciar at Q=6; idle ignores en/pausa
    add(1,0,0,1,0, 10, 10,0,0,1);
    add(0,0,0,1,0, 10, 9,0,0,1);
    add(0,0,0,1,0, 10, 8,0,0,1);
    add(0,0,0,1,0, 10, 7,0,0,1);
    add(0,0,0,1,0, 10, 6,0,0,1);
    add(1,1,0,1,0, 10, 0,0,0,0);
    add(0,0,1,1,0, 10, 0,0,0,0);
    // 5: restart at Q=4 with D=7, no rco for aborted count
    add(1,0,0,1,0, 10, 10,0,0,1);
    for (int k = 9; k >= 4; k--) add(0,0,0,1,0, 10, k,0,0,1);
    add(1,0,0,1,0, 7,  7,0,0,1);
    add(0,0,0,1,0, 7,  6,0,0,1);
    add(0,0,0,1,0, 7,  5,0,0,1);
    // 6: auto with D=0 fires rco on every tick; en low holds
    add(1,0,0,1,1, 0,  0,0,0,1);
    add(0,0,0,1,1, 0,  0,1,0,1);
    add(0,0,0,1,1, 0,  0,1,0,1);
    add(0,0,0,0,1, 0,  0,0,0,1);
    add(0,1,0,1,1, 0,  0,0,0,0);

    drive(0,0,0,0,0, '0);
    clr_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 check("reset_state", 0, 0, 0, 0);
    @(negedge clock);
    clr_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].iniciar, vecs[i].cancelar, vecs[i].pausa,
            vecs[i].en, vecs[i].auto, vecs[i].d);
      @(posedge clock);
      #1 check($sformatf("vec%0d", i), vecs[i].q, vecs[i].rco, vecs[i].fim, vecs[i].ativo);
    end

    // Asynchronous reset at Q=5, between edges
    @(negedge clock);
    drive(1,0,0,1,0, N'(9));
    @(posedge clock);
    #1 check("async_load9", 9, 0, 0, 1);
    @(negedge clock);
    drive(0,0,0,1,0, N'(9));
    repeat (4) @(posedge clock);
    #1 check("async_at5", 5, 0, 0, 1);
    #2 clr_n = 1'b0;
    #1 check("async_reset_immediate", 0, 0, 0, 0);
    @(negedge clock);
    clr_n = 1'b1;
    @(posedge clock);
    #1 check("post_reset_idle", 0, 0, 0, 0);

    // D=0 start: first tick is terminal, then FIM
    @(negedge clock);
    drive(1,0,0,0,0, '0);
    @(posedge clock);
    #1 check("d0_start", 0, 0, 0, 1);
    @(negedge clock);
    drive(0,0,0,1,0, '0);
    @(posedge clock);
    #1 check("d0_terminal", 0, 1, 1, 0);
    @(posedge clock);
    #1 check("d0_fim_hold", 0, 0, 1, 0);

    // Cancel out of FIM
    @(negedge clock);
    drive(0,1,0,0,0, '0);
    @(posedge clock);
    #1 check("fim_cancel", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
